// File: rtl/wave_capture_ctrl.sv
// Oscilloscope-style capture controller: on a rising zero crossing it writes 256
// samples into the back bank, then flips banks once the display goes idle.
module wave_capture_ctrl #(
  parameter int SAMPLE_W = 16,
  parameter int HOLDOFF  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index,
  output logic                buffer_flip,
  output logic                armed
);

  typedef enum logic [1:0] {S_HOLD, S_ARMED, S_ACTIVE, S_WAIT} state_t;

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_t                     r_state;
  logic [7:0]                 r_count;
  logic [HW-1:0]              r_hold;
  logic signed [SAMPLE_W-1:0] r_prev;
  logic                       r_read_index;
  logic                       r_we;
  logic [8:0]                 r_addr;
  logic [7:0]                 r_data;
  logic                       r_flip;
  logic                       r_armed;

  logic       w_trigger;
  logic [7:0] w_conv;

  assign w_trigger = new_sample_ready && (r_prev < 0) && ($signed(new_sample_in) >= 0);
  // Offset binary: invert the sign bit and keep the top 8 bits.
  assign w_conv    = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_ARMED;
      r_count      <= '0;
      r_hold       <= '0;
      r_prev       <= '0;
      r_read_index <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_flip       <= 1'b0;
      r_armed      <= 1'b1;
    end else begin
      r_we   <= 1'b0;
      r_flip <= 1'b0;
      if (new_sample_ready) r_prev <= new_sample_in;
      unique case (r_state)
        S_ARMED: begin
          if (w_trigger) begin
            r_we    <= 1'b1;
            r_addr  <= {~r_read_index, 8'h00};
            r_data  <= w_conv;
            r_count <= 8'd1;
            r_state <= S_ACTIVE;
            r_armed <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (new_sample_ready) begin
            r_we    <= 1'b1;
            r_addr  <= {~r_read_index, r_count};
            r_data  <= w_conv;
            r_count <= r_count + 8'd1;
            if (r_count == 8'hFF) r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wave_display_idle) begin
            r_read_index <= ~r_read_index;
            r_flip       <= 1'b1;
            r_hold       <= '0;
            if (HOLDOFF > 0) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_ARMED;
              r_armed <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (new_sample_ready) begin
            if (r_hold == HOLD_LAST) begin
              r_hold  <= '0;
              r_state <= S_ARMED;
              r_armed <= 1'b1;
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
        end
      endcase
    end
  end

  assign write_address = r_addr;
  assign write_enable  = r_we;
  assign write_sample  = r_data;
  assign read_index    = r_read_index;
  assign buffer_flip   = r_flip;
  assign armed         = r_armed;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Bench for wave_capture_ctrl: two instances (HOLDOFF 0 and 4) share stimulus and are
// checked every cycle against a capture-progress model, plus directed literal checks.
module tb_wave_capture_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, nsr, idle;
  logic [15:0] din;

  logic [8:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       we0, we1, rd0, rd1, flip0, flip1, armed0, armed1;

  wave_capture_ctrl #(.SAMPLE_W(16), .HOLDOFF(0)) u0 (
    .clk(clk), .reset(rst), .new_sample_ready(nsr), .new_sample_in(din),
    .wave_display_idle(idle), .write_address(addr0), .write_enable(we0),
    .write_sample(data0), .read_index(rd0), .buffer_flip(flip0), .armed(armed0)
  );

  wave_capture_ctrl #(.SAMPLE_W(16), .HOLDOFF(4)) u1 (
    .clk(clk), .reset(rst), .new_sample_ready(nsr), .new_sample_in(din),
    .wave_display_idle(idle), .write_address(addr1), .write_enable(we1),
    .write_sample(data1), .read_index(rd1), .buffer_flip(flip1), .armed(armed1)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int wc0 = 0, wc1 = 0;
  int last_addr0 = 0, last_addr1 = 0;

  // Model: m_filled = -1 while waiting for a trigger, 0..255 while capturing,
  // 256 once the bank is full; m_hold = strobes still to be ignored.
  int m_filled[2], m_hold[2], m_prev[2];
  int e_we[2], e_addr[2], e_data[2], e_rd[2], e_flip[2], e_armed[2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input int k, input int idx, input int s);
    e_we[k]   = 1;
    e_addr[k] = (e_rd[k] != 0 ? 0 : 256) + idx;
    e_data[k] = ((s >>> 8) + 128) & 255;
  endtask

  task automatic model_step(input int k);
    int s, hcfg;
    s    = int'($signed(din));
    hcfg = (k == 0) ? 0 : 4;
    if (rst) begin
      m_filled[k] = -1; m_hold[k] = 0; m_prev[k] = 0;
      e_rd[k] = 0; e_we[k] = 0; e_addr[k] = 0; e_data[k] = 0; e_flip[k] = 0;
    end else begin
      e_we[k]   = 0;
      e_flip[k] = 0;
      if (m_filled[k] == 256) begin
        if (idle) begin
          e_rd[k]     = 1 - e_rd[k];
          e_flip[k]   = 1;
          m_filled[k] = -1;
          m_hold[k]   = hcfg;
        end
      end else if (m_hold[k] > 0) begin
        if (nsr) m_hold[k]--;
      end else if (m_filled[k] < 0) begin
        if (nsr && m_prev[k] < 0 && s >= 0) begin
          put(k, 0, s);
          m_filled[k] = 1;
        end
      end else if (nsr) begin
        put(k, m_filled[k], s);
        m_filled[k]++;
      end
      if (nsr) m_prev[k] = s;
    end
    e_armed[k] = (m_filled[k] < 0 && m_hold[k] == 0) ? 1 : 0;
  endtask

  task automatic cmp(input int k, input logic we, input logic [8:0] a, input logic [7:0] d,
                     input logic rd, input logic flip, input logic arm);
    chk($sformatf("u%0d_write_enable", k), int'(we), e_we[k]);
    chk($sformatf("u%0d_write_address", k), int'(a), e_addr[k]);
    chk($sformatf("u%0d_write_sample", k), int'(d), e_data[k]);
    chk($sformatf("u%0d_read_index", k), int'(rd), e_rd[k]);
    chk($sformatf("u%0d_buffer_flip", k), int'(flip), e_flip[k]);
    chk($sformatf("u%0d_armed", k), int'(arm), e_armed[k]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        cmp(0, we0, addr0, data0, rd0, flip0, armed0);
        cmp(1, we1, addr1, data1, rd1, flip1, armed1);
        if (we0) begin wc0++; last_addr0 = int'(addr0); end
        if (we1) begin wc1++; last_addr1 = int'(addr1); end
      end
    end
  end

  task automatic cycle(input bit r, input bit n, input int v, input bit i);
    @(negedge clk);
    rst  = r;
    nsr  = n;
    din  = 16'(v);
    idle = i;
    model_step(0);
    model_step(1);
    chk_en = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  int base0, base1, first0, first1, a0, a1;
  int seq[6] = '{-1, 1, -1, 1, -1, 1};

  initial begin
    rst = 1'b1; nsr = 1'b0; idle = 1'b0; din = '0;

    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0); settle();
    chk("rst_armed", int'(armed0), 1);
    chk("rst_we", int'(we0), 0);
    chk("rst_addr", int'(addr0), 0);
    chk("rst_rd", int'(rd0), 0);
    chk("rst_flip", int'(flip0), 0);

    // Negative then non-negative sample triggers
    cycle(0, 1, -5, 0); settle();
    chk("neg_nowrite", int'(we0), 0);
    chk("neg_armed", int'(armed0), 1);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 3, 0); settle();
    chk("trig_we", int'(we0), 1);
    chk("trig_addr", int'(addr0), 'h100);
    chk("trig_data", int'(data0), 'h80);
    chk("trig_armed", int'(armed0), 0);
    cycle(0, 0, 0, 0); settle();
    chk("we_single", int'(we0), 0);
    chk("addr_hold", int'(addr0), 'h100);

    // No negative sample before the rise: no trigger
    cycle(1, 0, 0, 0); settle();
    base0 = wc0;
    cycle(0, 1, 0, 0); cycle(0, 1, 10, 0); cycle(0, 0, 0, 0); settle();
    chk("nontrig_writes", wc0 - base0, 0);
    chk("nontrig_armed", int'(armed0), 1);

    // Full 256-sample capture
    cycle(1, 0, 0, 0); settle();
    base0 = wc0;
    cycle(0, 1, -1, 0); cycle(0, 1, 1, 0);
    for (int i = 0; i < 255; i++) begin
      cycle(0, 1, int'($urandom_range(0, 65535)), 0);
      repeat ($urandom_range(0, 2)) cycle(0, 0, 0, 0);
    end
    cycle(0, 0, 0, 0); settle();
    chk("full_writes", wc0 - base0, 256);
    chk("full_last_addr", last_addr0, 'h1FF);
    chk("full_armed", int'(armed0), 0);
    cycle(0, 1, -7, 0); settle();
    chk("wait_nowrite", int'(we0), 0);
    cycle(0, 0, 0, 0); settle();
    chk("wait_writes", wc0 - base0, 256);

    // Idle together with a strobe flips the bank without writing
    cycle(0, 1, 5, 1); settle();
    chk("flip0_pulse", int'(flip0), 1);
    chk("flip0_rd", int'(rd0), 1);
    chk("flip0_nowrite", int'(we0), 0);
    chk("flip1_pulse", int'(flip1), 1);
    chk("flip1_rd", int'(rd1), 1);
    chk("flip0_armed", int'(armed0), 1);
    chk("flip1_holding", int'(armed1), 0);
    cycle(0, 0, 0, 0); settle();
    chk("flip0_single", int'(flip0), 0);

    // Holdoff: instance 0 triggers at once, instance 1 only after 4 ignored strobes
    first0 = 0; first1 = 0; a0 = -1; a1 = -1;
    base1 = wc1;
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 1, seq[i-1], 0); settle();
      if (we0 && first0 == 0) begin first0 = i; a0 = int'(addr0); end
      if (we1 && first1 == 0) begin first1 = i; a1 = int'(addr1); end
      cycle(0, 0, 0, 0);
    end
    chk("ho0_first", first0, 2);
    chk("ho0_addr", a0, 'h000);
    chk("ho1_first", first1, 6);
    chk("ho1_addr", a1, 'h000);

    // Reset after 100 writes aborts the capture
    for (int i = 0; i < 99; i++) cycle(0, 1, int'($urandom_range(0, 65535)), 0);
    cycle(0, 0, 0, 0); settle();
    chk("abort_writes", wc1 - base1, 100);
    chk("abort_rd_before", int'(rd1), 1);
    cycle(1, 0, 0, 0); settle();
    chk("abort_we", int'(we1), 0);
    chk("abort_rd", int'(rd1), 0);
    chk("abort_armed", int'(armed1), 1);
    chk("abort_rd0", int'(rd0), 0);
    cycle(0, 1, -1, 0); cycle(0, 1, 1, 0); settle();
    chk("restart_we", int'(we1), 1);
    chk("restart_addr", int'(addr1), 'h100);

    // Random traffic, including idle during capture and occasional resets
    for (int i = 0; i < 4000; i++) begin
      int v;
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 65535));
      else v = int'($urandom_range(0, 4000)) - 2000;
      cycle($urandom_range(0, 599) == 0, $urandom_range(0, 1) == 1, v,
            $urandom_range(0, 7) == 0);
    end
    cycle(0, 0, 0, 0); settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wave_capture_ctrl.md
WAVE_CAPTURE_CTRL -- requirements
Module: wave_capture_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 16: width of the signed audio sample input.
REQ-002 The block SHALL have parameter HOLDOFF, default 0: number of sample strobes ignored after a buffer flip before re-arming.
REQ-003 The block SHALL have port clk  input  1: system clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-005 The block SHALL have port new_sample_ready  input  1: single-cycle strobe, new_sample_in valid.
REQ-006 The block SHALL have port new_sample_in  input  SAMPLE_W: signed two's-complement audio sample.
REQ-007 The block SHALL have port wave_display_idle  input  1: high while the display is not scanning the waveform window.
REQ-008 The block SHALL have port write_address  output  9: RAM write address {bank, index[7:0]}.
REQ-009 The block SHALL have port write_enable  output  1: RAM write strobe, one cycle per written sample.
REQ-010 The block SHALL have port write_sample  output  8: offset-binary sample to RAM.
REQ-011 The block SHALL have port read_index  output  1: bank currently displayed; capture always writes bank ~read_index.
REQ-012 The block SHALL have port buffer_flip  output  1: one-cycle pulse on the cycle read_index toggles.
REQ-013 The block SHALL have port armed  output  1: high while in state ARMED.

Function
REQ-014 The block SHALL implement states HOLD, ARMED, ACTIVE, WAIT; state and all outputs SHALL be registered.
REQ-015 The block SHALL keep prev_sample (SAMPLE_W, signed) and update it with new_sample_in on every new_sample_ready, in every state.
REQ-016 In ARMED, the block SHALL detect a trigger when new_sample_ready=1, prev_sample<0 and new_sample_in>=0 (signed compare); it SHALL NOT trigger on any other condition.
REQ-017 On trigger, the block SHALL write the triggering sample at index 0, set count=1, and enter ACTIVE.
REQ-018 In ACTIVE, each new_sample_ready SHALL write the sample at index count, then increment count; the write of index 255 SHALL move the block to WAIT, with count wrapping to 0.
REQ-019 The sample conversion SHALL be write_sample = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]} (truncation, no rounding).
REQ-020 Each write SHALL set write_enable=1, write_address={~read_index, index} and write_sample in the cycle after the accepting strobe (latency 1); write_enable SHALL be 0 in all other cycles; write_address/write_sample SHALL hold between writes.
REQ-021 In WAIT, samples SHALL NOT be written; on the first cycle with wave_display_idle=1, the block SHALL toggle read_index, pulse buffer_flip for one cycle (registered, next cycle), and enter HOLD if HOLDOFF>0, else ARMED.
REQ-022 In HOLD, the block SHALL count HOLDOFF new_sample_ready strobes without writing or triggering, then enter ARMED; the holdoff counter SHALL clear on entry.
REQ-023 wave_display_idle SHALL be ignored in HOLD, ARMED and ACTIVE; read_index SHALL change only in WAIT.
REQ-024 A simultaneous new_sample_ready and wave_display_idle in WAIT SHALL flip the bank; that sample SHALL NOT be written or trigger, but SHALL update prev_sample.
REQ-025 armed SHALL equal (state==ARMED).

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL set state=ARMED, count=0, holdoff counter=0, prev_sample=0, read_index=0, write_enable=0, write_address=0, write_sample=0, buffer_flip=0 and armed=1 on the following cycle.
REQ-027 A reset asserted mid-ACTIVE or mid-WAIT SHALL abort capture without a flip; partial bank contents SHALL be left as-is.
REQ-028 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-029 Reset, then strobe samples -5 followed by +3 -> no write for -5; write at addr 9'h100 with data 8'h80 one cycle after the +3 strobe; armed goes 0.
REQ-030 Strobe 0 and then +10 with no negative sample in between -> no trigger, no writes, armed stays 1.
REQ-031 Trigger, then strobe 255 more samples -> exactly 256 writes to 9'h100..9'h1FF in order; state WAIT; the 257th strobe is not written.
REQ-032 In WAIT, assert wave_display_idle together with a strobe -> buffer_flip pulses once, read_index=1, no write; the next trigger writes to 9'h000.
REQ-033 With HOLDOFF=4, after a flip strobe the sequence -1,+1,-1,+1,-1,+1 -> the first valid trigger is the sixth strobe (+1 after the holdoff ends).
REQ-034 Reset asserted after 100 ACTIVE writes -> write_enable=0, read_index=0, armed=1 next cycle; the following -1,+1 pair restarts at 9'h100.
